// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants for the 640x480@60 Hz scan path.
// Also holds the scan-total derivation used by the sync generator.
package vga_timing_pkg;

   localparam int unsigned DEF_CLK_DIV   = 2;
   localparam int unsigned DEF_H_VISIBLE = 640;
   localparam int unsigned DEF_H_FRONT   = 16;
   localparam int unsigned DEF_H_SYNC    = 96;
   localparam int unsigned DEF_H_BACK    = 48;
   localparam int unsigned DEF_V_VISIBLE = 480;
   localparam int unsigned DEF_V_FRONT   = 10;
   localparam int unsigned DEF_V_SYNC    = 2;
   localparam int unsigned DEF_V_BACK    = 33;

   localparam int unsigned MAX_TOTAL   = 1024;
   localparam int unsigned MAX_CLK_DIV = 16;

   // Both syncs are active-low for this mode.
   localparam logic SYNC_ACTIVE = 1'b0;

   function automatic int unsigned scan_total(input int unsigned visible,
                                              input int unsigned front,
                                              input int unsigned sync,
                                              input int unsigned back);
      return visible + front + sync + back;
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with enable and wrap strobe; count_next exposes the
// value the register takes at the coming edge so callers can pre-decode.
module mod_counter #(
   parameter int unsigned MODULUS = 2,
   parameter int unsigned WIDTH   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] count_next,
   output logic             at_max,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   assign at_max = (count == LAST);
   assign wrap   = en && at_max;

   always_comb begin
      count_next = count;
      if (en) begin
         count_next = at_max ? '0 : count + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else begin
         count <= count_next;
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA scan timing generator: pixel-rate divider, h/v scan counters and
// registered sync/blanking decode aligned with the scan position.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
   parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
   parameter int unsigned H_FRONT   = DEF_H_FRONT,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_BACK    = DEF_H_BACK,
   parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
   parameter int unsigned V_FRONT   = DEF_V_FRONT,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_BACK    = DEF_V_BACK
) (
   input  logic       clk,
   input  logic       rst,
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_tick
);

   localparam int unsigned H_TOTAL = scan_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam int unsigned V_TOTAL = scan_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic [9:0] H_VIS_L  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS_L  = 10'(V_VISIBLE);

   if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL ||
       CLK_DIV < 1 || CLK_DIV > MAX_CLK_DIV) begin : g_bad_params
      $error("vga_sync_gen: illegal timing parameters");
   end

   logic [DIV_W-1:0] div_count;
   logic [DIV_W-1:0] div_next;
   logic             div_at_max;
   logic             h_wrap;
   logic             h_at_max;
   logic             v_at_max;
   logic [9:0]       h_next;
   logic [9:0]       v_next;
   logic             hsync_next;
   logic             vsync_next;
   logic             video_on_next;
   logic             unused_ok;

   mod_counter #(.MODULUS(CLK_DIV), .WIDTH(DIV_W)) u_div (
      .clk        (clk),
      .rst        (rst),
      .en         (1'b1),
      .count      (div_count),
      .count_next (div_next),
      .at_max     (div_at_max),
      .wrap       (p_tick)
   );

   mod_counter #(.MODULUS(H_TOTAL), .WIDTH(10)) u_h (
      .clk        (clk),
      .rst        (rst),
      .en         (p_tick),
      .count      (pixel_x),
      .count_next (h_next),
      .at_max     (h_at_max),
      .wrap       (h_wrap)
   );

   // Vertical wrap implies p_tick on the last pixel of the last line.
   mod_counter #(.MODULUS(V_TOTAL), .WIDTH(10)) u_v (
      .clk        (clk),
      .rst        (rst),
      .en         (h_wrap),
      .count      (pixel_y),
      .count_next (v_next),
      .at_max     (v_at_max),
      .wrap       (frame_tick)
   );

   assign unused_ok = &{1'b0, div_count, div_next, div_at_max, h_at_max, v_at_max};

   // Decoding the next-state position keeps syncs in step with pixel_x/pixel_y.
   always_comb begin
      hsync_next    = ~SYNC_ACTIVE;
      vsync_next    = ~SYNC_ACTIVE;
      video_on_next = (h_next < H_VIS_L) && (v_next < V_VIS_L);
      if (h_next >= HS_FIRST && h_next <= HS_LAST) begin
         hsync_next = SYNC_ACTIVE;
      end
      if (v_next >= VS_FIRST && v_next <= VS_LAST) begin
         vsync_next = SYNC_ACTIVE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hsync    <= ~SYNC_ACTIVE;
         vsync    <= ~SYNC_ACTIVE;
         video_on <= 1'b1;
      end else begin
         hsync    <= hsync_next;
         vsync    <= vsync_next;
         video_on <= video_on_next;
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default timing for reset/line checks,
// reduced timings (div 2 and div 1) for whole-frame checks.
module tb_vga_sync_gen;

   // Reduced timing: H 8+2+3+3 = 16, V 6+2+2+2 = 12.
   localparam int unsigned S_HT = 16;
   localparam int unsigned S_VT = 12;

   logic clk;
   logic rst_a, rst_b, rst_c;
   logic sel;

   logic       p_tick_a, video_on_a, hsync_a, vsync_a, frame_tick_a;
   logic [9:0] pixel_x_a, pixel_y_a;
   logic       p_tick_b, video_on_b, hsync_b, vsync_b, frame_tick_b;
   logic [9:0] pixel_x_b, pixel_y_b;
   logic       p_tick_c, video_on_c, hsync_c, vsync_c, frame_tick_c;
   logic [9:0] pixel_x_c, pixel_y_c;

   logic       m_p_tick, m_video_on, m_hsync, m_vsync, m_frame_tick;
   logic [9:0] m_x, m_y;

   int unsigned n_cmp;
   int unsigned n_bad;

   vga_sync_gen u_def (
      .clk(clk), .rst(rst_a), .p_tick(p_tick_a), .pixel_x(pixel_x_a),
      .pixel_y(pixel_y_a), .video_on(video_on_a), .hsync(hsync_a),
      .vsync(vsync_a), .frame_tick(frame_tick_a)
   );

   vga_sync_gen #(
      .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
   ) u_small (
      .clk(clk), .rst(rst_b), .p_tick(p_tick_b), .pixel_x(pixel_x_b),
      .pixel_y(pixel_y_b), .video_on(video_on_b), .hsync(hsync_b),
      .vsync(vsync_b), .frame_tick(frame_tick_b)
   );

   vga_sync_gen #(
      .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
   ) u_div1 (
      .clk(clk), .rst(rst_c), .p_tick(p_tick_c), .pixel_x(pixel_x_c),
      .pixel_y(pixel_y_c), .video_on(video_on_c), .hsync(hsync_c),
      .vsync(vsync_c), .frame_tick(frame_tick_c)
   );

   always_comb begin
      m_p_tick     = sel ? p_tick_c     : p_tick_b;
      m_video_on   = sel ? video_on_c   : video_on_b;
      m_hsync      = sel ? hsync_c      : hsync_b;
      m_vsync      = sel ? vsync_c      : vsync_b;
      m_frame_tick = sel ? frame_tick_c : frame_tick_b;
      m_x          = sel ? pixel_x_c    : pixel_x_b;
      m_y          = sel ? pixel_y_c    : pixel_y_b;
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Aligns on a frame_tick of the selected small instance, then walks one full frame.
   task automatic measure_frame(input string tag, input int unsigned exp_clocks,
                                input int unsigned exp_plow, input int unsigned exp_hold);
      bit          seen [S_VT][S_HT];
      bit          got = 0;
      int unsigned clocks = 0, plow = 0, dup = 0, distinct = 0, oob = 0;
      int unsigned vs_low = 0, vs_ymin = 999, vs_ymax = 0;
      int unsigned hs_low = 0, hs_xmin = 999, hs_xmax = 0;
      int unsigned von = 0, pos_ticks = 0, pos_clocks = 0, pos_von = 0;
      logic [9:0]  last_x = '0, last_y = '0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (m_frame_tick) begin
            got = 1;
            break;
         end
      end
      check({tag, "_align"}, 32'(got), 1);
      @(negedge clk);
      check({tag, "_wrap_x"}, 32'(m_x), 0);
      check({tag, "_wrap_y"}, 32'(m_y), 0);
      check({tag, "_origin_von"}, 32'(m_video_on), 1);
      got = 0;
      for (int i = 0; i < 1000; i++) begin
         clocks++;
         if (!m_p_tick) plow++;
         if (m_x == 0 && m_y == 7) begin
            pos_clocks++;
            if (m_video_on) pos_von++;
         end
         if (m_p_tick) begin
            if (m_x < S_HT && m_y < S_VT) begin
               if (seen[m_y][m_x]) dup++;
               else begin
                  seen[m_y][m_x] = 1'b1;
                  distinct++;
               end
            end else begin
               oob++;
            end
            if (!m_vsync) begin
               vs_low++;
               if (m_y < vs_ymin) vs_ymin = m_y;
               if (m_y > vs_ymax) vs_ymax = m_y;
            end
            if (!m_hsync) begin
               hs_low++;
               if (m_x < hs_xmin) hs_xmin = m_x;
               if (m_x > hs_xmax) hs_xmax = m_x;
            end
            if (m_video_on) von++;
            if (m_x == 0 && m_y == 7) pos_ticks++;
         end
         if (m_frame_tick) begin
            got = 1;
            last_x = m_x;
            last_y = m_y;
            break;
         end
         @(negedge clk);
      end
      check({tag, "_end_seen"}, 32'(got), 1);
      check({tag, "_frame_clocks"}, clocks, exp_clocks);
      check({tag, "_ptick_low"}, plow, exp_plow);
      check({tag, "_ft_x"}, 32'(last_x), 15);
      check({tag, "_ft_y"}, 32'(last_y), 11);
      check({tag, "_distinct"}, distinct, 192);
      check({tag, "_dup"}, dup, 0);
      check({tag, "_oob"}, oob, 0);
      check({tag, "_vs_low"}, vs_low, 32);
      check({tag, "_vs_ymin"}, vs_ymin, 8);
      check({tag, "_vs_ymax"}, vs_ymax, 9);
      check({tag, "_hs_low"}, hs_low, 36);
      check({tag, "_hs_xmin"}, hs_xmin, 10);
      check({tag, "_hs_xmax"}, hs_xmax, 12);
      check({tag, "_video_on"}, von, 48);
      check({tag, "_pos_ticks"}, pos_ticks, 1);
      check({tag, "_pos_hold"}, pos_clocks, exp_hold);
      check({tag, "_pos_von"}, pos_von, 0);
   endtask

   initial begin
      int unsigned ticks, hs_low, hs_first, hs_last, von, vs_low, held_bad;
      bit          got;
      n_cmp = 0;
      n_bad = 0;
      sel   = 1'b0;
      rst_a = 1'b0;
      rst_b = 1'b0;
      rst_c = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_x", 32'(pixel_x_a), 0);
      check("rst_y", 32'(pixel_y_a), 0);
      check("rst_hsync", 32'(hsync_a), 1);
      check("rst_vsync", 32'(vsync_a), 1);
      check("rst_video_on", 32'(video_on_a), 1);
      check("rst_ptick", 32'(p_tick_a), 0);
      check("rst_frame_tick", 32'(frame_tick_a), 0);
      check("rst_ptick_div1", 32'(p_tick_c), 1);

      // Release and first pixel step
      rst_a = 1'b1;
      rst_b = 1'b1;
      rst_c = 1'b1;
      @(negedge clk);
      check("first_ptick", 32'(p_tick_a), 1);
      check("x_held", 32'(pixel_x_a), 0);
      @(negedge clk);
      check("x_one", 32'(pixel_x_a), 1);
      check("ptick_drop", 32'(p_tick_a), 0);
      check("div1_ptick_run", 32'(p_tick_c), 1);

      // One full default line (y = 1)
      got = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (p_tick_a && pixel_x_a == 0 && pixel_y_a == 1) begin
            got = 1;
            break;
         end
      end
      check("line_align", 32'(got), 1);
      ticks = 0; hs_low = 0; hs_first = 9999; hs_last = 0; von = 0; vs_low = 0;
      for (int i = 0; i < 4000; i++) begin
         if (p_tick_a) begin
            if (ticks != 0 && pixel_x_a == 0) break;
            ticks++;
            if (video_on_a) von++;
            if (!vsync_a) vs_low++;
            if (!hsync_a) begin
               hs_low++;
               if (pixel_x_a < hs_first) hs_first = pixel_x_a;
               if (pixel_x_a > hs_last) hs_last = pixel_x_a;
            end
         end
         @(negedge clk);
      end
      check("line_ticks", ticks, 800);
      check("line_y_next", 32'(pixel_y_a), 2);
      check("hs_low", hs_low, 96);
      check("hs_first", hs_first, 656);
      check("hs_last", hs_last, 751);
      check("line_video_on", von, 640);
      check("line_vs_low", vs_low, 0);

      // hsync falls in the very first clock of x = 656
      got = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (p_tick_a && pixel_x_a == 655) begin
            got = 1;
            break;
         end
      end
      check("hs_edge_align", 32'(got), 1);
      check("hs_before", 32'(hsync_a), 1);
      @(negedge clk);
      check("hs_edge_x", 32'(pixel_x_a), 656);
      check("hs_edge", 32'(hsync_a), 0);

      // Full reduced frame, CLK_DIV = 2
      sel = 1'b0;
      measure_frame("f2", 384, 192, 2);

      // Reset mid-frame while hsync is active
      got = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (pixel_x_b == 11 && pixel_y_b == 5) begin
            got = 1;
            break;
         end
      end
      check("mid_reach", 32'(got), 1);
      check("mid_hs_low", 32'(hsync_b), 0);
      #2 rst_b = 1'b0;
      #1;
      check("mid_x", 32'(pixel_x_b), 0);
      check("mid_y", 32'(pixel_y_b), 0);
      check("mid_hsync", 32'(hsync_b), 1);
      check("mid_vsync", 32'(vsync_b), 1);
      check("mid_ptick", 32'(p_tick_b), 0);
      held_bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (pixel_x_b != 0 || pixel_y_b != 0 || !hsync_b || !vsync_b || frame_tick_b)
            held_bad++;
      end
      check("mid_hold", held_bad, 0);
      rst_b = 1'b1;
      @(negedge clk);
      check("mid_rel_ptick", 32'(p_tick_b), 1);
      check("mid_rel_x0", 32'(pixel_x_b), 0);
      @(negedge clk);
      check("mid_rel_x1", 32'(pixel_x_b), 1);
      measure_frame("f2r", 384, 192, 2);

      // Full reduced frame, CLK_DIV = 1
      sel = 1'b1;
      measure_frame("f1", 192, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing generator for the 640x480@60 Hz VGA path. Divides the system clock down to the pixel rate and runs horizontal and vertical scan counters. Produces `hsync`/`vsync` plus the `pixel_x`, `pixel_y` and `video_on` stream consumed by the pixel/colour generation block. All outputs are registered and mutually aligned, so downstream logic sees a coherent scan position on every clock.

## Interface
- `CLK_DIV`, 2: system clocks per pixel (50 MHz -> 25 MHz); legal 1..16
- `H_VISIBLE`, 640: active pixels per line
- `H_FRONT`, 16: horizontal front porch
- `H_SYNC`, 96: hsync pulse width
- `H_BACK`, 48: horizontal back porch
- `V_VISIBLE`, 480: active lines per frame
- `V_FRONT`, 10: vertical front porch
- `V_SYNC`, 2: vsync pulse width
- `V_BACK`, 33: vertical back porch
- `clk`  in  1  system clock; single clock domain, rising edge
- `rst`  in  1  reset, asynchronous assert, active-low
- `p_tick`  out  1  one-clock pixel-enable strobe
- `pixel_x`  out  10  horizontal position, 0..H_TOTAL-1
- `pixel_y`  out  10  vertical position, 0..V_TOTAL-1
- `video_on`  out  1  high when `pixel_x` < H_VISIBLE and `pixel_y` < V_VISIBLE
- `hsync`  out  1  horizontal sync, active-low
- `vsync`  out  1  vertical sync, active-low
- `frame_tick`  out  1  one-clock pulse on the last pixel of each frame

## Operation
- H_TOTAL = sum of the four H parameters (800). V_TOTAL = sum of the four V parameters (525). Both must be ≤ 1024, enforced by elaboration-time check.
- Divider: counter runs 0..CLK_DIV-1 and wraps. `p_tick` is high in the clock where the divider equals CLK_DIV-1. With CLK_DIV=1, `p_tick` is constantly high after reset.
- Horizontal counter: advances only on `p_tick`. At H_TOTAL-1 it wraps to 0 and enables one vertical step.
- Vertical counter: advances on `p_tick` when the horizontal counter equals H_TOTAL-1. At V_TOTAL-1 it wraps to 0.
- `hsync` is low while `pixel_x` is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. [656, 751].
- `vsync` is low while `pixel_y` is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. [490, 491].
- `hsync`, `vsync` and `video_on` are decoded from the next-state counter values and registered, so they change in the same clock as `pixel_x`/`pixel_y`.
- `frame_tick` = `p_tick` AND `pixel_x`==H_TOTAL-1 AND `pixel_y`==V_TOTAL-1, registered-free (combinational from registers).
- Every (x, y) pair occurs exactly once per frame. The position `pixel_y`==481, `pixel_x`==0 occurs once per frame and is held for CLK_DIV clocks.

## Timing
- Reset values (asynchronous): divider 0, `pixel_x` 0, `pixel_y` 0, `hsync` 1, `vsync` 1, `video_on` 1, `p_tick` 0 (1 if CLK_DIV=1), `frame_tick` 0.
- First `p_tick` is CLK_DIV clocks after reset release. `pixel_x` becomes 1 in the clock after that `p_tick`.
- Each position is held for exactly CLK_DIV clocks.
- Line period: H_TOTAL·CLK_DIV clocks. Frame period: H_TOTAL·V_TOTAL·CLK_DIV clocks (840000 at defaults).
- Reset asserted mid-frame: all outputs take reset values immediately, with no glitch pulse on syncs. Scanning restarts at (0,0) after release.
- Wrap of both counters happens in one clock edge: (799,524) -> (0,0).

## Structure
- Package `vga_timing_pkg`: default timing constants, H_TOTAL/V_TOTAL derivation, sync polarity constant.
- One sub-module, `mod_counter` (parameterised modulus and width, enable in, wrap-strobe out). Instantiated three times: divider, horizontal, vertical.
- Top level holds the sync/video decode and output registers.

## Test plan
- Reset then release -> outputs equal reset values; first `p_tick` 2 clocks after release; `pixel_x` reaches 1 at clock 3.
- Count one line -> 800 `p_tick`s between `pixel_x`=0 occurrences; `hsync` low for exactly 96 ticks starting at `pixel_x`=656.
- Run a full frame -> `vsync` low for lines 490-491 only (1600 ticks); `video_on` high for exactly 307200 ticks; one `frame_tick` at 840000 clocks.
- Check the position (x=0, y=481) -> appears once per frame, held 2 clocks, with `video_on`=0.
- Assert `rst` low at (x=700, y=300) for 3 clocks -> immediate return to (0,0) with `hsync`=1 and `vsync`=1; a full correct frame follows.
- Set CLK_DIV=1 -> `p_tick` constantly high; frame period 420000 clocks; sync positions unchanged.
